// File: rtl/fcs_xor_inserter_pkg.sv
// -----------------------------------------------------------------------------
// fcs_xor_inserter_pkg
// Items shared by the transmit-side FCS XOR inserter and the receive-side
// FCS checkers: the default CRC32 generator, the frame FSM state encoding and
// a single-bit CRC32 step function.
// -----------------------------------------------------------------------------
package fcs_xor_inserter_pkg;

    // 802.11 CRC32 generator; bit 31 holds the x^31 coefficient (x^32 implicit).
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        FCS     = 2'd2
    } fcs_state_e;

    // One MSB-first CRC step. With init 0 and no final complement this yields
    // the CRC delta caused by an XOR pattern, since CRC32 is linear.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic        b,
                                               input logic [31:0] poly = CRC_POLY);
        return {crc[30:0], 1'b0} ^ (poly & {32{b ^ crc[31]}});
    endfunction

endpackage

// File: rtl/fcs_xor_inserter_if.sv
// -----------------------------------------------------------------------------
// fcs_xor_inserter_if
// Bit-serial link between the payload modulation source, the FCS XOR inserter
// and the backscatter switch driver.
//   frame_start  : one-cycle pulse, starts a frame and samples payload_len
//   payload_len  : payload bit count
//   bit_strobe   : one pulse per on-air bit period
//   xor_in       : payload XOR bit, valid with bit_strobe
//   xor_out      : XOR bit for the switch driver
//   out_valid    : pulse one cycle after each accepted strobe
//   busy         : frame in progress
//   done         : pulse with the last FCS bit's out_valid
// master = the source side driving the frame; slave = the inserter.
// -----------------------------------------------------------------------------
interface fcs_xor_inserter_if #(
    parameter int LEN_W = 16
);
    logic             frame_start;
    logic [LEN_W-1:0] payload_len;
    logic             bit_strobe;
    logic             xor_in;
    logic             xor_out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output frame_start, payload_len, bit_strobe, xor_in,
        input  xor_out, out_valid, busy, done
    );

    modport slave (
        input  frame_start, payload_len, bit_strobe, xor_in,
        output xor_out, out_valid, busy, done
    );
endinterface

// File: rtl/fcs_xor_inserter.sv
// -----------------------------------------------------------------------------
// fcs_xor_inserter
// Passes the per-bit payload XOR pattern through to the backscatter switch and
// then appends the 32-bit FCS correction pattern (MSB / x^31 term first), so
// the modulated frame still carries a valid CRC32.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : fcs_xor_inserter_if.slave (frame_start, payload_len, bit_strobe,
//            xor_in in; xor_out, out_valid, busy, done out)
// LEN_W must match the interface instance's LEN_W and be at least 5 so the
// counter can hold the 31 used for the FCS phase.
// -----------------------------------------------------------------------------
module fcs_xor_inserter
    import fcs_xor_inserter_pkg::*;
#(
    parameter int          LEN_W    = 16,
    parameter logic [31:0] CRC_POLY = fcs_xor_inserter_pkg::CRC_POLY
) (
    input  logic               clk,
    input  logic               rst_n,
    fcs_xor_inserter_if.slave  bus
);

    localparam logic [LEN_W-1:0] FCS_LAST = LEN_W'(31);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    fcs_state_e       state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [31:0]      shift_q, shift_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             xor_out_q, xor_out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      crc_nxt;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        xor_out_d   = xor_out_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        crc_nxt     = crc32_step(crc_q, bus.xor_in, CRC_POLY);

        if (bus.frame_start) begin
            // Start (or abort-and-restart); any same-cycle strobe is dropped.
            crc_d   = '0;
            shift_d = '0;
            busy_d  = 1'b1;
            if (bus.payload_len == '0) begin
                state_d = FCS;
                cnt_d   = FCS_LAST;
            end else begin
                state_d = PAYLOAD;
                cnt_d   = bus.payload_len;
            end
        end else if (bus.bit_strobe) begin
            unique case (state_q)
                PAYLOAD: begin
                    xor_out_d   = bus.xor_in;
                    out_valid_d = 1'b1;
                    crc_d       = crc_nxt;
                    if (cnt_q == ONE) begin
                        // Load the final CRC straight into the shifter so the
                        // first FCS bit can go out on the very next strobe.
                        state_d = FCS;
                        cnt_d   = FCS_LAST;
                        shift_d = crc_nxt;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                FCS: begin
                    xor_out_d   = shift_q[31];
                    out_valid_d = 1'b1;
                    shift_d     = {shift_q[30:0], 1'b0};
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: ; // IDLE: strobes ignored
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            crc_q       <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            xor_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            xor_out_q   <= xor_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.xor_out   = xor_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_fcs_xor_inserter.sv
// -----------------------------------------------------------------------------
// tb_fcs_xor_inserter
// Randomized self-checking bench. The FCS reference is computed by long
// division of the augmented message (payload followed by 32 zeros) by the
// 33-bit generator, independent of the DUT's per-bit register update.
// -----------------------------------------------------------------------------
module tb_fcs_xor_inserter;

    localparam int          LEN_W = 16;
    localparam logic [31:0] POLY  = 32'h04C11DB7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fcs_xor_inserter_if #(.LEN_W(LEN_W)) bus ();

    fcs_xor_inserter #(.LEN_W(LEN_W), .CRC_POLY(POLY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int ov_cnt = 0;
    int dn_cnt = 0;
    int stray  = 0;

    // Pulse counters sampled at posedge: they see the value registered at the
    // previous edge, so reads from negedge-driven tasks never race them.
    always @(posedge clk) begin
        if (bus.out_valid) ov_cnt++;
        if (bus.done)      dn_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Augmented-message polynomial division: remainder of M(x)*x^32 mod G(x).
    function automatic logic [31:0] fcs_ref(input bit msg[$]);
        bit a[$];
        logic [31:0] r;
        a = msg;
        repeat (32) a.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++)
            if (a[i])
                for (int j = 0; j < 32; j++) a[i+1+j] ^= POLY[31-j];
        for (int j = 0; j < 32; j++) r[31-j] = a[msg.size()+j];
        return r;
    endfunction

    // Called just after a negedge; strobe is seen at the next posedge and the
    // result is sampled on the following negedge (1-clock latency).
    task automatic strobe(input bit x, input int gap_max,
                          output bit o, output bit v, output bit d, output bit b);
        int gap;
        bus.bit_strobe = 1'b1;
        bus.xor_in     = x;
        @(negedge clk);
        bus.bit_strobe = 1'b0;
        o = bus.xor_out; v = bus.out_valid; d = bus.done; b = bus.busy;
        gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        repeat (gap) begin
            @(negedge clk);
            if (bus.out_valid || bus.done) stray++;
        end
    endtask

    task automatic start(input int len, input bit collide);
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.payload_len = LEN_W'(len);
        bus.bit_strobe  = collide;
        bus.xor_in      = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.bit_strobe  = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit bits[$], input int gap_max, input bit collide);
        int ov0, dn0, st0, pay_bad, lat_bad;
        bit o, v, d, b, busy_at_done;
        logic [31:0] got;
        pay_bad = 0; lat_bad = 0; busy_at_done = 1'b1; got = '0;
        start(bits.size(), collide);
        ov0 = ov_cnt; dn0 = dn_cnt; st0 = stray;
        chk({tag, "_busy_start"}, bus.busy, 1);
        foreach (bits[i]) begin
            strobe(bits[i], gap_max, o, v, d, b);
            if (!v || o != bits[i] || d || !b) pay_bad++;
        end
        for (int k = 0; k < 32; k++) begin
            strobe(1'b0, gap_max, o, v, d, b);
            got[31-k] = o;
            if (!v || d != (k == 31)) lat_bad++;
            if (k == 31) busy_at_done = b;
        end
        @(negedge clk);
        chk({tag, "_payload"}, pay_bad, 0);
        chk({tag, "_fcs_valid_done"}, lat_bad, 0);
        chk({tag, "_fcs"}, got, fcs_ref(bits));
        chk({tag, "_busy_at_done"}, busy_at_done, 0);
        chk({tag, "_ov_count"}, ov_cnt - ov0, bits.size() + 32);
        chk({tag, "_done_count"}, dn_cnt - dn0, 1);
        chk({tag, "_stray"}, stray - st0, 0);
        chk({tag, "_busy_after"}, bus.busy, 0);
    endtask

    initial begin
        bit q[$];
        bit o, v, d, b;
        int ov0, dn0;

        rst_n = 1'b0;
        bus.frame_start = 1'b0; bus.payload_len = '0;
        bus.bit_strobe  = 1'b0; bus.xor_in      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.xor_out, bus.out_valid, bus.busy, bus.done}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Strobe while idle must be ignored.
        strobe(1'b1, 0, o, v, d, b);
        chk("idle_strobe_ignored", {v, d, b}, 3'b000);

        // len=64, all zero.
        q.delete(); repeat (64) q.push_back(1'b0);
        run_frame("zeros64", q, 0, 1'b0);

        // len=8, single 1 on the last bit -> FCS = generator.
        q.delete(); repeat (7) q.push_back(1'b0); q.push_back(1'b1);
        run_frame("last1_len8", q, 2, 1'b0);
        chk("last1_ref_const", fcs_ref(q), 32'h04C11DB7);

        // len=2, bits 1,0.
        q.delete(); q.push_back(1'b1); q.push_back(1'b0);
        run_frame("len2", q, 1, 1'b0);
        chk("len2_ref_const", fcs_ref(q), 32'h09823B6E);

        // len=0: FCS only, with a colliding strobe on frame_start.
        q.delete();
        run_frame("len0", q, 3, 1'b1);

        // Long random frame, 1..5 clocks between strobes.
        q.delete(); repeat (1000) q.push_back(1'($urandom_range(1, 0)));
        run_frame("rand1000", q, 4, 1'b0);

        // Few short random frames, back-to-back strobes.
        for (int f = 0; f < 4; f++) begin
            q.delete(); repeat ($urandom_range(40, 1)) q.push_back(1'($urandom_range(1, 0)));
            run_frame("rand_short", q, 0, f[0]);
        end

        // Reset asserted at FCS bit 10.
        dn0 = dn_cnt;
        start(12, 1'b0);
        repeat (12) strobe(1'($urandom_range(1, 0)), 1, o, v, d, b);
        repeat (10) strobe(1'b0, 1, o, v, d, b);
        #2 rst_n = 1'b0;
        #1 chk("midreset_outputs", {bus.xor_out, bus.out_valid, bus.busy, bus.done}, 4'b0000);
        @(negedge clk);
        chk("midreset_no_done", dn_cnt - dn0, 0);
        rst_n = 1'b1;
        q.delete(); repeat (20) q.push_back(1'($urandom_range(1, 0)));
        run_frame("after_reset", q, 2, 1'b0);

        // frame_start at payload bit 5 aborts and restarts.
        dn0 = dn_cnt;
        start(40, 1'b0);
        repeat (5) strobe(1'b1, 1, o, v, d, b);
        q.delete(); repeat (17) q.push_back(1'($urandom_range(1, 0)));
        run_frame("restart", q, 1, 1'b0);
        chk("restart_single_done", dn_cnt - dn0, 1);

        // Maximum length loads without wrap: stays in payload, then aborted.
        dn0 = dn_cnt;
        start((1 << LEN_W) - 1, 1'b0);
        ov0 = ov_cnt;
        repeat (200) strobe(1'b0, 0, o, v, d, b);
        @(negedge clk);
        chk("maxlen_ov", ov_cnt - ov0, 200);
        chk("maxlen_busy_no_done", {bus.busy, 32'(dn_cnt - dn0)}, {1'b1, 32'd0});
        q.delete(); repeat (9) q.push_back(1'($urandom_range(1, 0)));
        run_frame("after_maxlen", q, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
